// File: rtl/keccak_pad_stream_if.sv
// Stream bundle for the pad10*1 padder: AXI-Stream message input, padded-block output
// and the per-message MODE select.
interface keccak_pad_stream_if #(
    parameter int DATA_WIDTH = 64,
    parameter int RATE_BITS  = 1088
);
    localparam int UW = $clog2(DATA_WIDTH / 8);

    logic                  MODE;
    logic                  S_TVALID;
    logic                  S_TREADY;
    logic [DATA_WIDTH-1:0] S_TDATA;
    logic                  S_TLAST;
    logic [UW-1:0]         S_TUSER;
    logic                  M_TVALID;
    logic                  M_TREADY;
    logic [RATE_BITS-1:0]  M_TDATA;
    logic                  M_TLAST;

    modport master (
        output MODE, S_TVALID, S_TDATA, S_TLAST, S_TUSER, M_TREADY,
        input  S_TREADY, M_TVALID, M_TDATA, M_TLAST
    );

    modport slave (
        input  MODE, S_TVALID, S_TDATA, S_TLAST, S_TUSER, M_TREADY,
        output S_TREADY, M_TVALID, M_TDATA, M_TLAST
    );
endinterface

// File: rtl/keccak_pad_stream.sv
// SHA-3/SHAKE pad10*1 padder: packs byte-aligned message beats into RATE_BITS blocks,
// appends the domain suffix and final 0x80, and emits an extra block when the message fills the rate.
module keccak_pad_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int RATE_BITS  = 1088
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    keccak_pad_stream_if.slave   io_bus
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int WORDS      = RATE_BYTES / BYTES;
    localparam int UW         = $clog2(BYTES);
    localparam int NW         = UW + 1;
    localparam int WW         = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW         = $clog2(RATE_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                r_state;
    logic [WW-1:0]         r_wptr;
    logic [RATE_BITS-1:0]  r_block;
    logic                  r_extra;
    logic                  r_mode;
    logic                  r_in_msg;
    logic                  r_s_tready;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;

    logic                  w_hs;
    logic                  w_mode_eff;
    logic [7:0]            w_suffix;
    logic [NW-1:0]         w_n;
    logic [PW-1:0]         w_p;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_beat;
    logic [RATE_BITS-1:0]  w_block_wr;
    logic [RATE_BITS-1:0]  w_sfx_vec;
    logic [RATE_BITS-1:0]  w_end_vec;
    logic [RATE_BITS-1:0]  w_pad_blk;
    logic [RATE_BITS-1:0]  w_extra_blk;

    function automatic logic [7:0] suffix_of(input logic mode);
        return mode ? 8'h1F : 8'h06;
    endfunction

    assign io_bus.S_TREADY = r_s_tready;
    assign io_bus.M_TVALID = r_m_tvalid;
    assign io_bus.M_TDATA  = r_block;
    assign io_bus.M_TLAST  = r_m_tlast;

    // Beat masking, slot insertion and padding datapath for the current input beat.
    always_comb begin
        w_hs = io_bus.S_TVALID && r_s_tready;
        // The first beat of a message must already use the MODE it presents.
        w_mode_eff = r_in_msg ? r_mode : io_bus.MODE;
        w_suffix   = suffix_of(w_mode_eff);
        if (io_bus.S_TUSER == {UW{1'b0}}) begin
            w_n = NW'(BYTES);
        end else begin
            w_n = {1'b0, io_bus.S_TUSER};
        end
        w_p    = PW'(r_wptr) * PW'(BYTES) + PW'(w_n);
        w_full = (w_p == PW'(RATE_BYTES));

        w_beat = io_bus.S_TDATA;
        for (int j = 0; j < BYTES; j++) begin
            if (io_bus.S_TLAST && (NW'(j) >= w_n)) begin
                w_beat[8*j +: 8] = 8'h00;
            end else begin
                w_beat[8*j +: 8] = io_bus.S_TDATA[8*j +: 8];
            end
        end

        w_block_wr = r_block;
        for (int w = 0; w < WORDS; w++) begin
            if (r_wptr == WW'(w)) begin
                w_block_wr[w*DATA_WIDTH +: DATA_WIDTH] = w_beat;
            end else begin
                w_block_wr[w*DATA_WIDTH +: DATA_WIDTH] = r_block[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        w_sfx_vec   = {{(RATE_BITS-8){1'b0}}, w_suffix} << {w_p, 3'b000};
        w_end_vec   = {8'h80, {(RATE_BITS-8){1'b0}}};
        w_pad_blk   = w_block_wr ^ w_sfx_vec ^ w_end_vec;
        w_extra_blk = w_end_vec | {{(RATE_BITS-8){1'b0}}, suffix_of(r_mode)};
    end

    // Control FSM with registered handshake outputs and block register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= ST_IDLE;
            r_wptr     <= {WW{1'b0}};
            r_block    <= {RATE_BITS{1'b0}};
            r_extra    <= 1'b0;
            r_mode     <= 1'b0;
            r_in_msg   <= 1'b0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FILL;
                    r_s_tready <= 1'b1;
                end
                ST_FILL: begin
                    if (w_hs) begin
                        if (!r_in_msg) begin
                            r_mode <= io_bus.MODE;
                        end
                        r_in_msg <= !io_bus.S_TLAST;
                        if (!io_bus.S_TLAST) begin
                            r_block <= w_block_wr;
                            if (r_wptr == WW'(WORDS-1)) begin
                                r_state    <= ST_EMIT;
                                r_s_tready <= 1'b0;
                                r_m_tvalid <= 1'b1;
                                r_m_tlast  <= 1'b0;
                            end else begin
                                r_wptr <= r_wptr + WW'(1);
                            end
                        end else begin
                            r_state    <= ST_EMIT;
                            r_s_tready <= 1'b0;
                            r_m_tvalid <= 1'b1;
                            // A message ending exactly on the rate boundary needs a padding-only block.
                            if (w_full) begin
                                r_block   <= w_block_wr;
                                r_extra   <= 1'b1;
                                r_m_tlast <= 1'b0;
                            end else begin
                                r_block   <= w_pad_blk;
                                r_m_tlast <= 1'b1;
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (io_bus.M_TREADY) begin
                        if (r_extra) begin
                            r_block   <= w_extra_blk;
                            r_m_tlast <= 1'b1;
                            r_extra   <= 1'b0;
                        end else begin
                            r_block    <= {RATE_BITS{1'b0}};
                            r_wptr     <= {WW{1'b0}};
                            r_state    <= ST_FILL;
                            r_s_tready <= 1'b1;
                            r_m_tvalid <= 1'b0;
                            r_m_tlast  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_s_tready <= 1'b0;
                    r_m_tvalid <= 1'b0;
                    r_m_tlast  <= 1'b0;
                end
            endcase
        end
    end
endmodule
